// File: rtl/vga_scan_gen.sv
// VGA raster timing and live pixel coordinates; outputs registered, updating on the pixel-tick edge.
// No backpressure: free-running, divider and counters restart from the last back-porch pixel on reset.
module vga_scan_gen #(
  parameter int DIV    = 4,
  parameter int H_DISP = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_DISP = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       p_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_start
);

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [9:0]    X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]    X_VIS    = 10'(H_DISP);
  localparam logic [9:0]    Y_VIS    = 10'(V_DISP);
  localparam logic [9:0]    HS_BEG   = 10'(H_DISP + H_FP);
  localparam logic [9:0]    HS_END   = 10'(H_DISP + H_FP + H_SYNC);
  localparam logic [9:0]    VS_BEG   = 10'(V_DISP + V_FP);
  localparam logic [9:0]    VS_END   = 10'(V_DISP + V_FP + V_SYNC);

  logic [DW-1:0] div_q, div_d;
  logic [9:0]    x_q, x_d, y_q, y_d;
  logic          tick;
  logic          p_tick_q, hsync_q, hsync_d, vsync_q, vsync_d;
  logic          video_on_q, video_on_d, frame_start_q, frame_start_d;

  // Counters advance on the same edge that raises p_tick, so p_tick marks the new pixel.
  always_comb begin
    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + DW'(1);
    x_d   = x_q;
    y_d   = y_q;
    if (tick) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
    hsync_d       = !((x_d >= HS_BEG) && (x_d < HS_END));
    vsync_d       = !((y_d >= VS_BEG) && (y_d < VS_END));
    video_on_d    = (x_d < X_VIS) && (y_d < Y_VIS);
    frame_start_d = tick && (x_d == '0) && (y_d == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q         <= '0;
      x_q           <= X_LAST;
      y_q           <= Y_LAST;
      p_tick_q      <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      x_q           <= x_d;
      y_q           <= y_d;
      p_tick_q      <= tick;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign p_tick      = p_tick_q;
  assign x           = x_q;
  assign y           = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign frame_start = frame_start_q;

endmodule
